alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared 3-bit ALU.
// Define ALU_ARB_RR_EN for round-robin tie breaking (default: fixed priority to 0).

module ALU_3bit (
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic [2:0] sel,
    output logic [2:0] result,
    output logic       carry_out,
    output logic       zero,
    output logic       equal,
    output logic       less_than,
    output logic       greater_than
);

    logic [3:0] wide;

    // bit 3 of wide is the carry/borrow or the bit shifted out
    always_comb begin
        wide = 4'd0;
        unique case (sel)
            3'd0: wide = {1'b0, A} + {1'b0, B};
            3'd1: wide = {1'b0, A} - {1'b0, B};
            3'd2: wide = {1'b0, A & B};
            3'd3: wide = {1'b0, A | B};
            3'd4: wide = {1'b0, A ^ B};
            3'd5: wide = {1'b0, ~A};
            3'd6: wide = {A, 1'b0};
            3'd7: wide = {A[0], 1'b0, A[2:1]};
            default: wide = 4'd0;
        endcase
    end

    assign result       = wide[2:0];
    assign carry_out    = wide[3];
    assign zero         = (wide[2:0] == 3'd0);
    assign equal        = (A == B);
    assign less_than    = (A < B);
    assign greater_than = (A > B);

endmodule

module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_a,
    input  logic [2:0]       req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_a,
    input  logic [2:0]       req1_b,
    input  logic [2:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2:0]       rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [2:0] op_sel;
    logic       op_id;
    logic       last_grant;
    logic       tie_id;
    logic       gnt_id;
    logic       accept;
    logic       rsp_done;

    logic [2:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_eq;
    logic       alu_lt;
    logic       alu_gt;

`ifdef ALU_ARB_RR_EN
    assign tie_id = ~last_grant;
`else
    // fixed priority: requester 0 always wins a tie
    assign tie_id = 1'b0 & last_grant;
`endif

    assign gnt_id     = (req0_valid & req1_valid) ? tie_id : req1_valid;
    assign accept     = (state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = accept & ~gnt_id;
    assign req1_ready = accept & gnt_id;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign rsp_done   = rsp_valid & rsp_ready;

    ALU_3bit u_alu (
        .A            (op_a),
        .B            (op_b),
        .sel          (op_sel),
        .result       (alu_result),
        .carry_out    (alu_carry),
        .zero         (alu_zero),
        .equal        (alu_eq),
        .less_than    (alu_lt),
        .greater_than (alu_gt)
    );

    // control FSM: accept -> execute -> hold response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) state <= EXEC;
                EXEC:    state <= RESP;
                RESP:    if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // capture the granted operands so later input changes cannot leak in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= 3'd0;
            op_b       <= 3'd0;
            op_sel     <= 3'd0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_a       <= gnt_id ? req1_a : req0_a;
            op_b       <= gnt_id ? req1_b : req0_b;
            op_sel     <= gnt_id ? req1_sel : req0_sel;
            op_id      <= gnt_id;
            last_grant <= gnt_id;
        end
    end

    // register the ALU outputs once, held stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= 3'd0;
            rsp_flags  <= 5'd0;
        end else if (state == EXEC) begin
            rsp_id     <= op_id;
            rsp_result <= alu_result;
            rsp_flags  <= {alu_gt, alu_lt, alu_eq, alu_zero, alu_carry};
        end
    end

    // saturating per-requester completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_done) begin
            if (!rsp_id && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
            if (rsp_id && cnt1 != '1)  cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule
